// File: rtl/wb_fifo_port_if.sv
// Wishbone classic register-window signals for the buffered stream port.
// The slave modport is used by wb_fifo_port; the master modport by whatever
// drives the I/O sub-bus.
interface wb_fifo_port_if;
  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic        err_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_fifo_port.sv
// Buffered Wishbone-to-stream bridge. A DATA/STATUS/CONTROL register window
// fronts a TX FIFO (bus -> device stream) and an RX FIFO (device stream ->
// bus), with occupancy reporting, flushes, sticky TX overflow and a level irq.
module wb_fifo_port #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_fifo_port_if.slave         wb,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_valid,
  input  logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  output logic                  read_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [PW-1:0]         tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CW-1:0]         tx_count_q, tx_count_d, rx_count_q, rx_count_d;

  // Register window state
  logic        rx_irq_en_q, tx_irq_en_q, tx_ovf_q;
  logic        ack_q, ack_d, err_q, err_d, irq_q;
  logic [31:0] dat_q, dat_d;

  // Per-edge events decoded from the bus request and the stream handshakes
  logic req, tx_push, tx_pop, rx_push, rx_pop;
  logic ctrl_we, rx_flush, tx_flush, ovf_set, ovf_clr;
  logic tx_full, tx_empty, rx_full, rx_nonempty;
  logic [31:0] status_word, rx_word;

  assign tx_full     = (tx_count_q == CW'(DEPTH));
  assign tx_empty    = (tx_count_q == '0);
  assign rx_full     = (rx_count_q == CW'(DEPTH));
  assign rx_nonempty = (rx_count_q != '0);

  assign write_valid = !tx_empty;
  assign write_data  = tx_mem_q[tx_rd_ptr_q];
  // Held low while reset is asserted so the producer never sees a ready
  // FIFO that is about to be cleared.
  assign read_ready  = rst & !rx_full;

  assign tx_pop  = write_valid & write_ready;
  assign rx_push = read_valid & read_ready;

  // A new request is ignored during the single termination cycle.
  assign req = wb.stb_i & wb.cyc_i & !ack_q & !err_q;

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign irq      = irq_q;

  // Assemble the STATUS and DATA read words with counts zero-extended.
  always_comb begin
    status_word                = '0;
    status_word[CW-1:0]        = rx_count_q;
    status_word[8 +: CW]       = tx_count_q;
    status_word[16]            = rx_nonempty;
    status_word[17]            = tx_full;
    status_word[18]            = tx_empty;
    status_word[19]            = tx_ovf_q;
    rx_word                    = '0;
    rx_word[DATA_WIDTH-1:0]    = rx_mem_q[rx_rd_ptr_q];
    rx_word[31]                = 1'b1;
  end

  // Decode one bus request into its termination, read data and side effects.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    ctrl_we  = 1'b0;
    rx_flush = 1'b0;
    tx_flush = 1'b0;
    ovf_set  = 1'b0;
    ovf_clr  = 1'b0;
    if (req) begin
      ack_d = 1'b1;
      dat_d = '0;
      case (wb.adr_i)
        ADR_DATA: begin
          if (wb.we_i) begin
            if (wb.sel_i[0]) begin
              if (tx_full) begin
                ack_d   = 1'b0;
                err_d   = 1'b1;
                ovf_set = 1'b1;
              end else begin
                tx_push = 1'b1;
              end
            end
          end else if (rx_nonempty) begin
            dat_d  = rx_word;
            rx_pop = 1'b1;
          end
        end
        ADR_STATUS: begin
          if (!wb.we_i) dat_d = status_word;
        end
        ADR_CTRL: begin
          if (wb.we_i) begin
            ctrl_we = wb.sel_i[0];
            if (wb.sel_i[1]) begin
              rx_flush = wb.dat_i[8];
              tx_flush = wb.dat_i[9];
              ovf_clr  = wb.dat_i[10];
            end
          end else begin
            dat_d = {30'b0, tx_irq_en_q, rx_irq_en_q};
          end
        end
        default: begin
          ack_d = 1'b0;
          err_d = 1'b1;
        end
      endcase
    end
  end

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  // TX FIFO pointers and count; a flush overrides a same-edge stream pop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block evaluation order.
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PW'(1);
      tx_count_q <= tx_count_d;
    end
  end

  // RX FIFO pointers and count; a flush discards a same-edge stream push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PW'(1);
      rx_count_q <= rx_count_d;
    end
  end

  // FIFO storage writes; contents are only observed behind a valid count.
  always_ff @(posedge clk) begin
    // NOTE: the word arrays are deliberately not reset; pointers and counts
    // define validity, and leaving them out keeps them in plain RAM.
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wb.dat_i[DATA_WIDTH-1:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= read_data;
  end

  // Bus termination, read data, control bits, sticky overflow and irq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      if (ctrl_we) begin
        rx_irq_en_q <= wb.dat_i[0];
        tx_irq_en_q <= wb.dat_i[1];
      end
      if (ovf_set)      tx_ovf_q <= 1'b1;
      else if (ovf_clr) tx_ovf_q <= 1'b0;
      irq_q <= (rx_irq_en_q & rx_nonempty) | (tx_irq_en_q & tx_empty);
    end
  end

endmodule
